// File: rtl/fifo_sync_ptr_gray.sv
// Multi-channel Gray pointer synchronizer into the write clock domain, with
// registered binary decode, update strobe and illegal-step (multi-bit) checking.
module fifo_sync_ptr_gray #(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2,
    parameter int NUM_CH   = 1,
    parameter int ERRW     = 8
) (
    input  logic                             wclk,
    input  logic                             wrst_n,
    input  logic [NUM_CH*(ADDRSIZE+1)-1:0]   rptr,
    input  logic [NUM_CH-1:0]                err_clr,
    output logic [NUM_CH*(ADDRSIZE+1)-1:0]   wq_rptr,
    output logic [NUM_CH*(ADDRSIZE+1)-1:0]   wq_rbin,
    output logic [NUM_CH-1:0]                rptr_upd,
    output logic [NUM_CH-1:0]                gray_err,
    output logic [NUM_CH*ERRW-1:0]           err_cnt
);

    localparam int PW = ADDRSIZE + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("fifo_sync_ptr_gray: STAGES must be in 2..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("fifo_sync_ptr_gray: NUM_CH must be in 1..8");
    end

    // Tracks how far post-reset data has travelled down the chain. The first
    // real value reaching the last stage replaces the reset zero, which is not
    // a Gray step, so error checking is held off until the chain is filled.
    logic [STAGES-1:0] vld;
    logic              arm;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            vld <= '0;
        end else begin
            vld <= {vld[STAGES-2:0], 1'b1};
        end
    end

    assign arm = vld[STAGES-1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0]   stage [STAGES];
        logic [PW-1:0]   d;
        logic [PW-1:0]   d_m1;
        logic [PW-1:0]   bin;
        logic [PW-1:0]   rbin_q;
        logic            chg_q;
        logic            err_q;
        logic            upd_q;
        logic            gerr_q;
        logic [ERRW-1:0] cnt_q;

        assign d    = stage[STAGES-1] ^ stage[STAGES-2];
        assign d_m1 = d - PW'(1);

        always_comb begin
            bin = '0;
            for (int unsigned i = 0; i < PW; i++) begin
                bin[i] = ^(stage[STAGES-1] >> i);
            end
        end

        // chg_q/err_q hold the detection one cycle so the strobe and error
        // flags land in the same cycle as the registered binary decode.
        always_ff @(posedge wclk) begin
            if (!wrst_n) begin
                for (int unsigned i = 0; i < STAGES; i++) begin
                    stage[i] <= '0;
                end
                chg_q  <= 1'b0;
                err_q  <= 1'b0;
                upd_q  <= 1'b0;
                rbin_q <= '0;
                gerr_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                stage[0] <= rptr[c*PW +: PW];
                for (int unsigned i = 1; i < STAGES; i++) begin
                    stage[i] <= stage[i-1];
                end
                chg_q  <= (d != '0);
                err_q  <= arm && ((d & d_m1) != '0);
                upd_q  <= chg_q;
                rbin_q <= bin;
                if (err_q) begin
                    gerr_q <= 1'b1;
                    if (err_clr[c]) begin
                        cnt_q <= ERRW'(1);
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + ERRW'(1);
                    end
                end else if (err_clr[c]) begin
                    gerr_q <= 1'b0;
                    cnt_q  <= '0;
                end
            end
        end

        assign wq_rptr[c*PW +: PW]     = stage[STAGES-1];
        assign wq_rbin[c*PW +: PW]     = rbin_q;
        assign rptr_upd[c]             = upd_q;
        assign gray_err[c]             = gerr_q;
        assign err_cnt[c*ERRW +: ERRW] = cnt_q;
    end

endmodule

// File: tb/tb_fifo_sync_ptr_gray.sv
// Directed bench: a 2-stage/2-channel instance and a 4-stage/1-channel instance
// sharing clock and reset.
module tb_fifo_sync_ptr_gray;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  rptr2;
    logic [1:0]  clr2;
    logic [9:0]  wq2;
    logic [9:0]  rbin2;
    logic [1:0]  upd2;
    logic [1:0]  gerr2;
    logic [15:0] cnt2;

    logic [4:0]  rptr4;
    logic [0:0]  clr4;
    logic [4:0]  wq4;
    logic [4:0]  rbin4;
    logic [0:0]  upd4;
    logic [0:0]  gerr4;
    logic [7:0]  cnt4;

    int nvec = 0;
    int nerr = 0;

    fifo_sync_ptr_gray #(.ADDRSIZE(4), .STAGES(2), .NUM_CH(2), .ERRW(8)) u2 (
        .wclk(clk), .wrst_n(rst_n), .rptr(rptr2), .err_clr(clr2),
        .wq_rptr(wq2), .wq_rbin(rbin2), .rptr_upd(upd2), .gray_err(gerr2), .err_cnt(cnt2)
    );

    fifo_sync_ptr_gray #(.ADDRSIZE(4), .STAGES(4), .NUM_CH(1), .ERRW(8)) u4 (
        .wclk(clk), .wrst_n(rst_n), .rptr(rptr4), .err_clr(clr4),
        .wq_rptr(wq4), .wq_rbin(rbin4), .rptr_upd(upd4), .gray_err(gerr4), .err_cnt(cnt4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int settle);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < settle; i++) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rptr2 = '1;
        rptr4 = '1;
        clr2  = '0;
        clr4  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if ({wq2, rbin2, upd2, gerr2, cnt2} !== 40'h0) begin
                nerr++;
                $display("FAIL reset_hold_u2 cyc%0d: got %h expected 0", i, {wq2, rbin2, upd2, gerr2, cnt2});
            end
            nvec++;
            if ({wq4, rbin4, upd4, gerr4, cnt4} !== 20'h0) begin
                nerr++;
                $display("FAIL reset_hold_u4 cyc%0d: got %h expected 0", i, {wq4, rbin4, upd4, gerr4, cnt4});
            end
        end
        rst_n = 1'b1;
        tick();
        nvec++;
        if ({wq2, rbin2, upd2, gerr2, cnt2} !== 40'h0) begin
            nerr++;
            $display("FAIL reset_release_edge1: got %h expected 0", {wq2, rbin2, upd2, gerr2, cnt2});
        end
        tick();
        nvec++;
        if (wq2 !== 10'b11111_11111 || rbin2 !== 10'h0 || upd2 !== 2'b00) begin
            nerr++;
            $display("FAIL reset_release_edge2: wq=%b rbin=%b upd=%b expected wq=1111111111 rbin=0 upd=00", wq2, rbin2, upd2);
        end
        tick();
        nvec++;
        if (rbin2 !== 10'b10101_10101 || upd2 !== 2'b11 || gerr2 !== 2'b00 || cnt2 !== 16'h0) begin
            nerr++;
            $display("FAIL reset_release_edge3: rbin=%b upd=%b gerr=%b cnt=%h expected rbin=1010110101 upd=11 gerr=00 cnt=0",
                     rbin2, upd2, gerr2, cnt2);
        end
        tick();
        nvec++;
        if (upd2 !== 2'b00 || gerr2 !== 2'b00) begin
            nerr++;
            $display("FAIL reset_release_edge4: upd=%b gerr=%b expected 00 00", upd2, gerr2);
        end
    endtask

    task automatic test_latency_decode;
        logic [4:0] gseq [5] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110};
        logic [4:0] bseq [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
        logic [4:0] pg;
        logic [4:0] pb;
        logic [4:0] ewq;
        logic [4:0] eb;
        logic       eu;
        rptr2 = '0;
        rptr4 = '0;
        pulse_reset(6);
        pg = '0;
        pb = '0;
        for (int k = 0; k < 5; k++) begin
            rptr2[4:0] = gseq[k];
            for (int t = 1; t <= 4; t++) begin
                tick();
                ewq = (t >= 2) ? gseq[k] : pg;
                eb  = (t >= 3) ? bseq[k] : pb;
                eu  = (t == 3) && (gseq[k] != pg);
                nvec++;
                if (wq2[4:0] !== ewq || rbin2[4:0] !== eb || upd2 !== {1'b0, eu} || gerr2 !== 2'b00) begin
                    nerr++;
                    $display("FAIL latency step%0d t%0d: wq=%b rbin=%0d upd=%b gerr=%b expected wq=%b rbin=%0d upd=0%b gerr=00",
                             k, t, wq2[4:0], rbin2[4:0], upd2, gerr2, ewq, eb, eu);
                end
            end
            pg = gseq[k];
            pb = bseq[k];
        end
    endtask

    task automatic test_illegal_step;
        rptr2[9:5] = 5'b00011;
        tick();
        tick();
        nvec++;
        if (wq2[9:5] !== 5'b00011 || upd2 !== 2'b00 || gerr2 !== 2'b00) begin
            nerr++;
            $display("FAIL illegal_sync: wq1=%b upd=%b gerr=%b expected 00011 00 00", wq2[9:5], upd2, gerr2);
        end
        tick();
        nvec++;
        if (upd2 !== 2'b10 || gerr2 !== 2'b10 || cnt2 !== 16'h0100 || rbin2[9:5] !== 5'd2) begin
            nerr++;
            $display("FAIL illegal_flag: upd=%b gerr=%b cnt=%h rbin1=%0d expected 10 10 0100 2", upd2, gerr2, cnt2, rbin2[9:5]);
        end
        tick();
        nvec++;
        if (upd2 !== 2'b00 || gerr2 !== 2'b10) begin
            nerr++;
            $display("FAIL illegal_after: upd=%b gerr=%b expected 00 10", upd2, gerr2);
        end
        for (int i = 1; i < 300; i++) begin
            rptr2[9:5] = rptr2[9:5] ^ 5'b00011;
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        nvec++;
        if (cnt2[15:8] !== 8'd255 || gerr2 !== 2'b10 || wq2[9:5] !== 5'b00000 || cnt2[7:0] !== 8'd0) begin
            nerr++;
            $display("FAIL illegal_saturate: cnt1=%0d cnt0=%0d gerr=%b wq1=%b expected 255 0 10 00000",
                     cnt2[15:8], cnt2[7:0], gerr2, wq2[9:5]);
        end
    endtask

    task automatic test_clear_collision;
        rptr2[9:5] = 5'b00011;
        tick();
        tick();
        clr2 = 2'b10;
        tick();
        clr2 = 2'b00;
        nvec++;
        if (gerr2 !== 2'b10 || cnt2 !== 16'h0100 || upd2 !== 2'b10) begin
            nerr++;
            $display("FAIL clear_collision: gerr=%b cnt=%h upd=%b expected 10 0100 10", gerr2, cnt2, upd2);
        end
        tick();
        clr2 = 2'b10;
        tick();
        clr2 = 2'b00;
        nvec++;
        if (gerr2 !== 2'b00 || cnt2 !== 16'h0000) begin
            nerr++;
            $display("FAIL clear_alone: gerr=%b cnt=%h expected 00 0000", gerr2, cnt2);
        end
    endtask

    task automatic test_wrap_depth;
        logic [4:0] gseq [2] = '{5'b10000, 5'b00000};
        logic [4:0] bseq [2] = '{5'd31, 5'd0};
        logic [4:0] pg;
        logic [4:0] pb;
        logic [4:0] ewq;
        logic [4:0] eb;
        logic       eu;
        rptr2 = '0;
        rptr4 = 5'b11000;
        pulse_reset(8);
        nvec++;
        if (wq4 !== 5'b11000 || rbin4 !== 5'd16 || gerr4 !== 1'b0 || cnt4 !== 8'd0) begin
            nerr++;
            $display("FAIL wrap_preload: wq=%b rbin=%0d gerr=%b cnt=%0d expected 11000 16 0 0", wq4, rbin4, gerr4, cnt4);
        end
        pg = 5'b11000;
        pb = 5'd16;
        for (int k = 0; k < 2; k++) begin
            rptr4 = gseq[k];
            for (int t = 1; t <= 6; t++) begin
                tick();
                ewq = (t >= 4) ? gseq[k] : pg;
                eb  = (t >= 5) ? bseq[k] : pb;
                eu  = (t == 5);
                nvec++;
                if (wq4 !== ewq || rbin4 !== eb || upd4 !== eu || gerr4 !== 1'b0 || cnt4 !== 8'd0) begin
                    nerr++;
                    $display("FAIL wrap step%0d t%0d: wq=%b rbin=%0d upd=%b gerr=%b cnt=%0d expected %b %0d %b 0 0",
                             k, t, wq4, rbin4, upd4, gerr4, cnt4, ewq, eb, eu);
                end
            end
            pg = gseq[k];
            pb = bseq[k];
        end
    endtask

    task automatic test_reset_midop;
        rptr2[4:0] = 5'b00001;
        tick();
        rptr2[4:0] = 5'b00011;
        rst_n = 1'b0;
        tick();
        nvec++;
        if ({wq2, rbin2, upd2, gerr2, cnt2} !== 40'h0 || {wq4, rbin4, upd4, gerr4, cnt4} !== 20'h0) begin
            nerr++;
            $display("FAIL midop_reset: u2=%h u4=%h expected 0 0", {wq2, rbin2, upd2, gerr2, cnt2}, {wq4, rbin4, upd4, gerr4, cnt4});
        end
        rst_n = 1'b1;
        tick();
        nvec++;
        if ({wq2, rbin2, upd2, gerr2, cnt2} !== 40'h0) begin
            nerr++;
            $display("FAIL midop_edge1: got %h expected 0", {wq2, rbin2, upd2, gerr2, cnt2});
        end
        tick();
        nvec++;
        if (wq2[4:0] !== 5'b00011 || upd2 !== 2'b00 || rbin2[4:0] !== 5'd0) begin
            nerr++;
            $display("FAIL midop_edge2: wq=%b upd=%b rbin=%0d expected 00011 00 0", wq2[4:0], upd2, rbin2[4:0]);
        end
        tick();
        nvec++;
        if (rbin2[4:0] !== 5'd2 || upd2 !== 2'b01 || gerr2 !== 2'b00 || cnt2 !== 16'h0) begin
            nerr++;
            $display("FAIL midop_edge3: rbin=%0d upd=%b gerr=%b cnt=%h expected 2 01 00 0", rbin2[4:0], upd2, gerr2, cnt2);
        end
        tick();
        nvec++;
        if (upd2 !== 2'b00 || gerr2 !== 2'b00 || cnt2 !== 16'h0) begin
            nerr++;
            $display("FAIL midop_edge4: upd=%b gerr=%b cnt=%h expected 00 00 0", upd2, gerr2, cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_latency_decode();
        test_illegal_step();
        test_clear_collision();
        test_wrap_depth();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
